// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rtc_pkg
// Description : Shared constants and helpers for the V3023 RTC timer
//               programming path: bank indices of the timer registers,
//               RTC register addresses, the transfer command byte and a
//               packed-BCD validity check.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  // Bank indices holding the timer seconds / minutes / hours
  localparam logic [3:0] REG_SEG = 4'd6;
  localparam logic [3:0] REG_MIN = 4'd7;
  localparam logic [3:0] REG_HOR = 4'd8;

  // RTC register addresses for the same timer fields
  localparam logic [7:0] ADDR_SEG = 8'h41;
  localparam logic [7:0] ADDR_MIN = 8'h42;
  localparam logic [7:0] ADDR_HOR = 8'h43;

  // Command byte: RAM -> reserved area transfer
  localparam logic [7:0] CMD_TRANSFER = 8'hF0;

  // True when both nibbles of a packed-BCD byte are in 0..9
  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_banco_bcd.sv
`default_nettype none
// ============================================================================
// Module      : rtc_banco_bcd
// Description : NREG x DATA_W register bank for the RTC sequencer.
//               Two synchronous write ports (user, read-back capture) and
//               one asynchronous read port.
// Ports       : Clock, Reset          - clock, sync active-high reset
//               i_usr_we/addr/data    - user write (already BCD-qualified)
//               i_cap_we/addr/data    - read-back capture write
//               i_rd_addr, o_rd_data  - combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_banco_bcd #(
  parameter int DATA_W = 8,
  parameter int NREG   = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_usr_we,
  input  logic [3:0]        i_usr_addr,
  input  logic [DATA_W-1:0] i_usr_data,
  input  logic              i_cap_we,
  input  logic [3:0]        i_cap_addr,
  input  logic [DATA_W-1:0] i_cap_data,
  input  logic [3:0]        i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [NREG];

  // A capture to the same index as a user write takes precedence; the
  // user write is simply dropped in that case.
  logic w_usr_do;
  assign w_usr_do = i_usr_we && !(i_cap_we && (i_cap_addr == i_usr_addr));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_usr_do) begin
        r_mem[i_usr_addr] <= i_usr_data;
      end
      if (i_cap_we) begin
        r_mem[i_cap_addr] <= i_cap_data;
      end
    end
  end

  // Read sees pre-edge contents; no write forwarding.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/rtc_bus_datos.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_datos
// Description : Data-path stage of the RTC timer-programming sequencer.
//               Selects the byte for the multiplexed AD bus (command,
//               bank data or address), registers it with its output
//               enable, and captures bytes read back from the RTC.
// Ports       : Clock, Reset           - clock, sync active-high reset
//               direccion, add_reg     - address byte / bank index
//               sd, cmd, sent_a/sent_d - phase selections and strobes
//               rd_n, rd_idx, ad_in    - read-back strobe, index, pad data
//               usr_we/addr/data       - user bank write (packed BCD)
//               ad_out, ad_oe          - AD bus byte and output enable
//               err_bcd, rd_valid      - reject / capture pulses
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_datos
  import rtc_pkg::*;
#(
  parameter int               DATA_W       = 8,
  parameter int               NREG         = 16,
  parameter logic [DATA_W-1:0] CMD_TRANSFER = rtc_pkg::CMD_TRANSFER
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] direccion,
  input  logic [3:0]        add_reg,
  input  logic              sd,
  input  logic              cmd,
  input  logic              sent_a,
  input  logic              sent_d,
  input  logic              rd_n,
  input  logic [3:0]        rd_idx,
  input  logic [DATA_W-1:0] ad_in,
  input  logic              usr_we,
  input  logic [3:0]        usr_addr,
  input  logic [DATA_W-1:0] usr_data,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              err_bcd,
  output logic              rd_valid
);

  logic [DATA_W-1:0] r_ad_out;
  logic              r_ad_oe;
  logic              r_err_bcd;
  logic              r_rd_valid;
  logic              r_rd_n_q;
  logic [DATA_W-1:0] r_ad_in_q;
  logic              r_conflict;

  logic [DATA_W-1:0] w_bank_rd;
  logic [DATA_W-1:0] w_byte;
  logic              w_load;
  logic              w_bcd_ok;
  logic              w_usr_we;
  logic              w_rd_rise;
  logic              w_cap_we;

  // Byte selection, priority cmd > data phase > address phase
  always_comb begin
    w_byte = r_ad_out;
    w_load = 1'b0;
    if (sd) begin
      if (cmd) begin
        w_byte = CMD_TRANSFER;
        w_load = 1'b1;
      end else if (sent_d) begin
        w_byte = w_bank_rd;
        w_load = 1'b1;
      end else if (sent_a) begin
        w_byte = direccion;
        w_load = 1'b1;
      end
    end
  end

  assign w_bcd_ok  = bcd_ok(usr_data);
  assign w_usr_we  = usr_we && w_bcd_ok;
  assign w_rd_rise = !r_rd_n_q && rd_n;
  assign w_cap_we  = w_rd_rise && !r_conflict;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ad_out   <= '0;
      r_ad_oe    <= 1'b0;
      r_err_bcd  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_n_q   <= 1'b1;
      r_ad_in_q  <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_load) begin
        r_ad_out <= w_byte;
      end
      r_ad_oe    <= sd;
      r_err_bcd  <= usr_we && !w_bcd_ok;
      r_rd_valid <= w_cap_we;
      r_rd_n_q   <= rd_n;
      // Hold the pad value seen while rd_n is low; the capture uses this
      // copy because ad_in is no longer driven once rd_n has risen.
      if (!rd_n) begin
        r_ad_in_q <= ad_in;
        // Any overlap of the read strobe with our own bus drive poisons
        // the whole low phase; restart tracking at each falling edge.
        if (r_rd_n_q) begin
          r_conflict <= r_ad_oe;
        end else begin
          r_conflict <= r_conflict || r_ad_oe;
        end
      end
    end
  end

  rtc_banco_bcd #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_banco (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_usr_we   (w_usr_we),
    .i_usr_addr (usr_addr),
    .i_usr_data (usr_data),
    .i_cap_we   (w_cap_we),
    .i_cap_addr (rd_idx),
    .i_cap_data (r_ad_in_q),
    .i_rd_addr  (add_reg),
    .o_rd_data  (w_bank_rd)
  );

  assign ad_out   = r_ad_out;
  assign ad_oe    = r_ad_oe;
  assign err_bcd  = r_err_bcd;
  assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_datos.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_datos
// Description : Directed self-checking bench for rtc_bus_datos.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_datos;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] direccion;
  logic [3:0] add_reg;
  logic       sd, cmd, sent_a, sent_d;
  logic       rd_n;
  logic [3:0] rd_idx;
  logic [7:0] ad_in;
  logic       usr_we;
  logic [3:0] usr_addr;
  logic [7:0] usr_data;
  logic [7:0] ad_out;
  logic       ad_oe, err_bcd, rd_valid;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  rtc_bus_datos dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .direccion (direccion),
    .add_reg   (add_reg),
    .sd        (sd),
    .cmd       (cmd),
    .sent_a    (sent_a),
    .sent_d    (sent_d),
    .rd_n      (rd_n),
    .rd_idx    (rd_idx),
    .ad_in     (ad_in),
    .usr_we    (usr_we),
    .usr_addr  (usr_addr),
    .usr_data  (usr_data),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .err_bcd   (err_bcd),
    .rd_valid  (rd_valid)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; direccion = '0; add_reg = '0; sd = 0; cmd = 0;
    sent_a = 0; sent_d = 0; rd_n = 1; rd_idx = '0; ad_in = '0;
    usr_we = 0; usr_addr = '0; usr_data = '0;
    tick(); tick();
    Reset = 1'b0;
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_ad_oe", {7'd0, ad_oe}, 8'h00);
    check("rst_err", {7'd0, err_bcd}, 8'h00);
    check("rst_rd_valid", {7'd0, rd_valid}, 8'h00);

    // Address phase
    sd = 1; sent_a = 1; direccion = 8'h41;
    tick();
    check("addr_out", ad_out, 8'h41);
    check("addr_oe", {7'd0, ad_oe}, 8'h01);
    // sd high, no strobe: hold
    sent_a = 0; direccion = 8'h99;
    tick();
    check("hold_out", ad_out, 8'h41);
    check("hold_oe", {7'd0, ad_oe}, 8'h01);
    // sd falls: oe drops, byte kept
    sd = 0;
    tick();
    check("sdfall_oe", {7'd0, ad_oe}, 8'h00);
    check("sdfall_out", ad_out, 8'h41);

    // Valid user write, then data phase
    usr_we = 1; usr_addr = 4'd7; usr_data = 8'h59;
    tick();
    usr_we = 0;
    check("usr_ok_err", {7'd0, err_bcd}, 8'h00);
    sd = 1; sent_d = 1; add_reg = 4'd7;
    tick();
    check("data7_out", ad_out, 8'h59);

    // Invalid BCD write
    sd = 0; sent_d = 0;
    usr_we = 1; usr_addr = 4'd6; usr_data = 8'h5A;
    tick();
    usr_we = 0;
    check("bad_bcd_err", {7'd0, err_bcd}, 8'h01);
    tick();
    check("bad_bcd_err_end", {7'd0, err_bcd}, 8'h00);
    sd = 1; sent_d = 1; add_reg = 4'd6;
    tick();
    check("data6_out", ad_out, 8'h00);

    // Command priority over address strobe
    sent_d = 0; cmd = 1; sent_a = 1; direccion = 8'h00;
    tick();
    check("cmd_out", ad_out, 8'hF0);
    cmd = 0; sent_a = 0; sd = 0;
    tick();

    // Read capture into index 8
    rd_n = 0; ad_in = 8'h23; rd_idx = 4'd8;
    tick(); tick(); tick();
    check("rd_low_valid", {7'd0, rd_valid}, 8'h00);
    rd_n = 1; ad_in = 8'hEE;
    tick();
    check("rd_valid_pulse", {7'd0, rd_valid}, 8'h01);
    tick();
    check("rd_valid_end", {7'd0, rd_valid}, 8'h00);
    sd = 1; sent_d = 1; add_reg = 4'd8;
    tick();
    check("data8_out", ad_out, 8'h23);

    // Bus conflict: read while driving, capture suppressed
    sent_d = 0;
    tick();
    rd_n = 0; ad_in = 8'h77; rd_idx = 4'd9;
    tick(); tick();
    rd_n = 1;
    tick();
    check("conflict_valid", {7'd0, rd_valid}, 8'h00);
    sent_d = 1; add_reg = 4'd9;
    tick();
    check("data9_out", ad_out, 8'h00);

    // Same-cycle capture and user write to index 8
    sd = 0; sent_d = 0;
    tick();
    rd_n = 0; ad_in = 8'h31; rd_idx = 4'd8;
    tick(); tick();
    rd_n = 1; usr_we = 1; usr_addr = 4'd8; usr_data = 8'h45;
    tick();
    usr_we = 0;
    check("coll_valid", {7'd0, rd_valid}, 8'h01);
    check("coll_err", {7'd0, err_bcd}, 8'h00);
    sd = 1; sent_d = 1; add_reg = 4'd8;
    tick();
    check("coll_data8", ad_out, 8'h31);

    // Reset mid-transfer
    sent_d = 0; sent_a = 1; direccion = 8'h42;
    tick();
    check("mid_out", ad_out, 8'h42);
    check("mid_oe", {7'd0, ad_oe}, 8'h01);
    Reset = 1;
    tick();
    check("mid_rst_oe", {7'd0, ad_oe}, 8'h00);
    check("mid_rst_out", ad_out, 8'h00);
    Reset = 0; sent_a = 0; sd = 0;
    tick();
    // Bank cleared by reset (index 7 held 8'h59)
    sd = 1; sent_d = 1; add_reg = 4'd7;
    tick();
    check("post_rst_data7", ad_out, 8'h00);
    sd = 0; sent_d = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
